// File: rtl/wave_pkg.sv
// Shared constants, FSM state type and index-wrap helper for the wavetable reader.
package wave_pkg;

  localparam int IDX_W   = 16;
  localparam int PHASE_W = 32;
  localparam int DATA_W  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE_A   = 3'd1,
    ISSUE_B   = 3'd2,
    WAIT      = 3'd3,
    CAPTURE_B = 3'd4,
    OUTPUT    = 3'd5
  } wr_state_t;

  // Index of the second interpolation tap; wraps to 0 at the end of the table.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] width);
    logic [IDX_W-1:0] nxt;
    nxt = idx + IDX_W'(1);
    return (nxt == width) ? '0 : nxt;
  endfunction

endpackage

// File: rtl/lerp_unit.sv
// Registered linear interpolation: y = a + (((b - a) * frac8) >>> 8).
module lerp_unit #(
  parameter int DW = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [7:0]    frac8_i,
  input  logic          in_valid_i,
  output logic [DW-1:0] y_o,
  output logic          out_valid_o
);

  logic signed [DW:0]   diff;
  logic signed [DW+9:0] prod;
  logic signed [DW+9:0] shifted;
  logic        [DW-1:0] y_d;
  logic        [DW-1:0] y_q;
  logic                 valid_q;
  logic                 unused_hi;

  assign diff    = $signed({b_i[DW-1], b_i}) - $signed({a_i[DW-1], a_i});
  assign prod    = (DW+10)'(diff) * (DW+10)'($signed({1'b0, frac8_i}));
  assign shifted = prod >>> 8;
  // The blended value always lies between a and b, so the low bits carry the full result.
  assign y_d       = a_i + shifted[DW-1:0];
  assign unused_hi = ^shifted[DW+9:DW];

  // Capture the blend one cycle after its operands; output holds between pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) y_q <= y_d;
    end
  end

  assign y_o         = y_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/wave_reader.sv
// Wavetable playback reader: 16.16 phase accumulator, two-tap fetch, linear blend.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a sample tick
// ISSUE_A   | first tap address on the RAM port, phase advances
// ISSUE_B   | second (wrapped) tap address on the RAM port
// WAIT      | RAM pipeline latency; tap A captured on the last cycle
// CAPTURE_B | tap B on ram_data_in, fed straight into the blend stage
// OUTPUT    | blended sample presented with its valid pulse
//
// RAM_LATENCY must be at least 2 so that tap A lands in WAIT.
module wave_reader
  import wave_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int INDEX_WIDTH = IDX_W,
  parameter int FRAC_WIDTH  = PHASE_W - IDX_W,
  parameter int RAM_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              sample_tick_in,
  input  logic                              note_on_in,
  input  logic [INDEX_WIDTH+FRAC_WIDTH-1:0] phase_inc_in,
  input  logic [INDEX_WIDTH-1:0]            wave_width_in,
  input  logic                              reload_in,
  output logic [INDEX_WIDTH-1:0]            osc_index_out,
  output logic                              osc_is_on_out,
  input  logic [DATA_WIDTH-1:0]             ram_data_in,
  output logic [DATA_WIDTH-1:0]             sample_out,
  output logic                              sample_valid_out,
  output logic                              overrun_out
);

  localparam int PW     = INDEX_WIDTH + FRAC_WIDTH;
  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RAM_LATENCY - 2);

  wr_state_t               state_q;
  logic [PW-1:0]           phase_q;
  logic [INDEX_WIDTH-1:0]  osc_index_q;
  logic                    osc_is_on_q;
  logic                    overrun_q;
  logic [7:0]              frac8_q;
  logic [DATA_WIDTH-1:0]   data_a_q;
  logic [WAIT_W-1:0]       wait_cnt_q;

  logic [INDEX_WIDTH-1:0]  idx_cur;
  logic                    idx_oob;
  logic                    gate_off;
  logic [PW-1:0]           width_ph;
  logic [PW-1:0]           phase_sum_d;
  logic [PW-1:0]           phase_sub_d;
  logic [PW-1:0]           phase_adv_d;

  logic [DATA_WIDTH-1:0]   lerp_a;
  logic [DATA_WIDTH-1:0]   lerp_b;
  logic [7:0]              lerp_frac;
  logic                    lerp_go;

  assign idx_cur     = phase_q[PW-1 -: INDEX_WIDTH];
  assign idx_oob     = idx_cur >= wave_width_in;
  assign gate_off    = !note_on_in || (wave_width_in == '0);
  assign width_ph    = {wave_width_in, {FRAC_WIDTH{1'b0}}};
  assign phase_sum_d = phase_q + phase_inc_in;
  assign phase_sub_d = phase_sum_d - width_ph;

  // Wrap the advanced phase once; a step larger than a whole table restarts at 0.
  always_comb begin
    phase_adv_d = phase_sum_d;
    if (phase_sum_d[PW-1 -: INDEX_WIDTH] >= wave_width_in) begin
      if (phase_sub_d[PW-1 -: INDEX_WIDTH] >= wave_width_in) phase_adv_d = '0;
      else                                                   phase_adv_d = phase_sub_d;
    end
  end

  // Blend-stage operands: silent zero for a gated tick, the two taps otherwise.
  always_comb begin
    lerp_a    = '0;
    lerp_b    = '0;
    lerp_frac = '0;
    lerp_go   = 1'b0;
    if (!reload_in) begin
      if (state_q == IDLE && sample_tick_in && gate_off) begin
        lerp_go = 1'b1;
      end else if (state_q == CAPTURE_B) begin
        lerp_a    = data_a_q;
        lerp_b    = ram_data_in;
        lerp_frac = frac8_q;
        lerp_go   = 1'b1;
      end
    end
  end

  // Fetch sequencer with registered RAM-port outputs and sticky overrun.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      osc_index_q <= '0;
      osc_is_on_q <= 1'b0;
      overrun_q   <= 1'b0;
      frac8_q     <= '0;
      data_a_q    <= '0;
      wait_cnt_q  <= '0;
    end else if (reload_in) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      osc_is_on_q <= 1'b0;
    end else begin
      if (sample_tick_in && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_tick_in) begin
            if (gate_off) begin
              phase_q <= '0;
            end else begin
              state_q     <= ISSUE_A;
              osc_is_on_q <= 1'b1;
              if (idx_oob) begin
                phase_q     <= '0;
                osc_index_q <= '0;
                frac8_q     <= '0;
              end else begin
                osc_index_q <= idx_cur;
                frac8_q     <= phase_q[FRAC_WIDTH-1 -: 8];
              end
            end
          end
        end
        ISSUE_A: begin
          phase_q     <= phase_adv_d;
          osc_index_q <= wrap_inc(osc_index_q, wave_width_in);
          state_q     <= ISSUE_B;
        end
        ISSUE_B: begin
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            data_a_q <= ram_data_in;
            state_q  <= CAPTURE_B;
          end else begin
            wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
          end
        end
        CAPTURE_B: begin
          osc_is_on_q <= 1'b0;
          state_q     <= OUTPUT;
        end
        OUTPUT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  lerp_unit #(.DW(DATA_WIDTH)) u_lerp (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .a_i         (lerp_a),
    .b_i         (lerp_b),
    .frac8_i     (lerp_frac),
    .in_valid_i  (lerp_go),
    .y_o         (sample_out),
    .out_valid_o (sample_valid_out)
  );

  assign osc_index_out = osc_index_q;
  assign osc_is_on_out = osc_is_on_q;
  assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_wave_reader.sv
// Bench for wave_reader: vector table, multi-cycle corner sequences, random ticks vs. a phase model.
module tb_wave_reader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_tick_in;
  logic        note_on_in;
  logic [31:0] phase_inc_in;
  logic [15:0] wave_width_in;
  logic        reload_in;
  logic [15:0] osc_index_out;
  logic        osc_is_on_out;
  logic [15:0] ram_data_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic        overrun_out;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] ram [0:255];
  logic [15:0] ram_p1 = '0;
  logic [15:0] ram_p2 = '0;
  longint mphase;

  typedef struct {
    int grp;
    bit note;
    int width;
    int inc;
    int exp_val;
    int exp_off;
    int exp_a1;
    int exp_a2;
  } vec_t;
  vec_t vecs[$];

  wave_reader dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_tick_in   (sample_tick_in),
    .note_on_in       (note_on_in),
    .phase_inc_in     (phase_inc_in),
    .wave_width_in    (wave_width_in),
    .reload_in        (reload_in),
    .osc_index_out    (osc_index_out),
    .osc_is_on_out    (osc_is_on_out),
    .ram_data_in      (ram_data_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-stage RAM read pipeline that advances while the read port is enabled.
  always @(posedge clk_in) begin
    if (osc_is_on_out) begin
      ram_p1 <= ram[osc_index_out[7:0]];
      ram_p2 <= ram_p1;
    end
  end
  assign ram_data_in = ram_p2;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endfunction

  function automatic void add(input int g, input bit n, input int w, input int inc,
                              input int v, input int o, input int a1, input int a2);
    vec_t r;
    r.grp = g; r.note = n; r.width = w; r.inc = inc;
    r.exp_val = v; r.exp_off = o; r.exp_a1 = a1; r.exp_a2 = a2;
    vecs.push_back(r);
  endfunction

  function automatic int floor256(input int num);
    if (num >= 0) return num / 256;
    return -((-num + 255) / 256);
  endfunction

  // Reference: what one tick should produce, from the phase/interpolation rules.
  function automatic void model_tick(input bit note, input int w, input int inc,
                                     output int y, output int off, output int a1, output int a2);
    longint p;
    int idx, f, a, b;
    p = mphase;
    if (!note || w == 0) begin
      mphase = 0; y = 0; off = 1; a1 = -1; a2 = -1;
      return;
    end
    idx = int'(p / 65536);
    if (idx >= w) begin p = 0; idx = 0; end
    f  = int'((p % 65536) / 256);
    a1 = idx;
    a2 = (idx + 1) % w;
    a  = int'(ram[a1]);
    b  = int'(ram[a2]);
    y  = a + floor256((b - a) * f);
    p  = (p + longint'(unsigned'(inc))) % 64'h1_0000_0000;
    if (p / 65536 >= w) p = p - longint'(w) * 65536;
    if (p / 65536 >= w) p = 0;
    mphase = p;
    off = 5;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    sample_tick_in = 1'b0;
    reload_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 100);
  endtask

  task automatic setup_group(input int g);
    apply_reset();
    fill_ramp();
    case (g)
      1: begin ram[3] = 16'sd1000; ram[4] = 16'sd2000; end
      2: ram[3] = 16'sd400;
      3: ram[3] = -16'sd400;
      default: ;
    endcase
  endtask

  // One tick, then watch gap cycles for valid pulses and the issued addresses.
  task automatic do_tick(input bit note, input int w, input int inc, input int gap,
                         output int nv, output int off, output int val,
                         output int a1, output int a2, output int seen_on);
    note_on_in = note;
    wave_width_in = w[15:0];
    phase_inc_in = inc;
    sample_tick_in = 1'b1;
    nv = 0; off = -1; val = 0; a1 = -1; a2 = -1; seen_on = 0;
    for (int k = 1; k <= gap; k++) begin
      step();
      if (k == 1) begin
        sample_tick_in = 1'b0;
        a1 = int'(osc_index_out);
      end
      if (k == 2) a2 = int'(osc_index_out);
      if (osc_is_on_out) seen_on = 1;
      if (sample_valid_out) begin
        nv++;
        if (off < 0) begin
          off = k;
          val = int'($signed(sample_out));
        end
      end
    end
  endtask

  initial begin
    int nv, off, val, a1, a2, on;
    int cur, w, inc, ev, eo, ea1, ea2;
    bit nt;

    rst_in = 1'b0; sample_tick_in = 1'b0; note_on_in = 1'b0; reload_in = 1'b0;
    phase_inc_in = '0; wave_width_in = '0;
    fill_ramp();
    apply_reset();
    check("rst_index", osc_index_out, 0);
    check("rst_on", osc_is_on_out, 0);
    check("rst_sample", sample_out, 0);
    check("rst_valid", sample_valid_out, 0);
    check("rst_overrun", overrun_out, 0);

    // ---------------- vector table ----------------
    for (int k = 0; k < 10; k++) add(0, 1, 8, 'h10000, (k % 8) * 100, 5, k % 8, (k + 1) % 8);
    add(0, 0, 8, 'h10000, 0, 1, -1, -1);
    add(0, 1, 8, 'h10000, 0, 5, 0, 1);
    add(0, 1, 0, 'h10000, 0, 1, -1, -1);
    add(1, 1, 8, 'h8000,    0, 5, 0, 1);
    add(1, 1, 8, 'h8000,   50, 5, 0, 1);
    add(1, 1, 8, 'h8000,  100, 5, 1, 2);
    add(1, 1, 8, 'h8000,  150, 5, 1, 2);
    add(1, 1, 8, 'h8000,  200, 5, 2, 3);
    add(1, 1, 8, 'h8000,  600, 5, 2, 3);
    add(1, 1, 8, 'h8000, 1000, 5, 3, 4);
    add(1, 1, 8, 'h8000, 1500, 5, 3, 4);
    add(2, 1, 4, 'h8000,    0, 5, 0, 1);
    add(2, 1, 4, 'h8000,   50, 5, 0, 1);
    add(2, 1, 4, 'h8000,  100, 5, 1, 2);
    add(2, 1, 4, 'h8000,  150, 5, 1, 2);
    add(2, 1, 4, 'h8000,  200, 5, 2, 3);
    add(2, 1, 4, 'h8000,  300, 5, 2, 3);
    add(2, 1, 4, 'h8000,  400, 5, 3, 0);
    add(2, 1, 4, 'h8000,  200, 5, 3, 0);
    add(3, 1, 4, 'h8000,    0, 5, 0, 1);
    add(3, 1, 4, 'h8000,   50, 5, 0, 1);
    add(3, 1, 4, 'h8000,  100, 5, 1, 2);
    add(3, 1, 4, 'h8000,  150, 5, 1, 2);
    add(3, 1, 4, 'h8000,  200, 5, 2, 3);
    add(3, 1, 4, 'h8000, -100, 5, 2, 3);
    add(3, 1, 4, 'h8000, -400, 5, 3, 0);
    add(3, 1, 4, 'h8000, -200, 5, 3, 0);

    cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].grp != cur) begin
        cur = vecs[i].grp;
        setup_group(cur);
      end
      do_tick(vecs[i].note, vecs[i].width, vecs[i].inc, 20, nv, off, val, a1, a2, on);
      check($sformatf("vec%0d_count", i), nv, 1);
      check($sformatf("vec%0d_value", i), val, vecs[i].exp_val);
      check($sformatf("vec%0d_latency", i), off, vecs[i].exp_off);
      if (vecs[i].exp_a1 >= 0) begin
        check($sformatf("vec%0d_addr_a", i), a1, vecs[i].exp_a1);
        check($sformatf("vec%0d_addr_b", i), a2, vecs[i].exp_a2);
      end else begin
        check($sformatf("vec%0d_port_off", i), on, 0);
      end
    end

    // ---------------- overrun: ticks at T and T+2 ----------------
    setup_group(0);
    note_on_in = 1'b1; wave_width_in = 16'd8; phase_inc_in = 32'h10000;
    sample_tick_in = 1'b1;
    step(); sample_tick_in = 1'b0;
    step();
    check("ovr_before", overrun_out, 0);
    sample_tick_in = 1'b1;
    step(); sample_tick_in = 1'b0;
    check("ovr_at_t3", overrun_out, 1);
    nv = 0; off = -1;
    for (int k = 3; k <= 12; k++) begin
      if (k > 3) step();
      if (sample_valid_out) begin
        nv++;
        if (off < 0) off = k;
      end
    end
    check("ovr_pulses", nv, 1);
    check("ovr_pulse_at", off, 5);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    check("ovr_next_value", val, 100);
    check("ovr_sticky", overrun_out, 1);

    // ---------------- reload mid-fetch ----------------
    setup_group(0);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    sample_tick_in = 1'b1;
    step(); sample_tick_in = 1'b0;
    step();
    step();
    reload_in = 1'b1;
    step(); reload_in = 1'b0;
    check("rld_port_off", osc_is_on_out, 0);
    nv = 0;
    for (int k = 4; k <= 10; k++) begin
      if (k > 4) step();
      if (sample_valid_out) nv++;
    end
    check("rld_no_pulse", nv, 0);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    check("rld_next_addr", a1, 0);
    check("rld_next_value", val, 0);
    sample_tick_in = 1'b1; reload_in = 1'b1;
    step(); sample_tick_in = 1'b0; reload_in = 1'b0;
    nv = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      if (sample_valid_out) nv++;
    end
    check("rld_tick_pulses", nv, 0);
    check("rld_tick_overrun", overrun_out, 0);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    check("rld_tick_addr", a1, 0);

    // ---------------- async reset during WAIT ----------------
    setup_group(0);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    sample_tick_in = 1'b1;
    step(); sample_tick_in = 1'b0;
    step();
    sample_tick_in = 1'b1;
    step(); sample_tick_in = 1'b0;
    check("arst_pre_on", osc_is_on_out, 1);
    check("arst_pre_index", osc_index_out, 3);
    check("arst_pre_sample", sample_out, 100);
    check("arst_pre_overrun", overrun_out, 1);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_index", osc_index_out, 0);
    check("arst_on", osc_is_on_out, 0);
    check("arst_sample", sample_out, 0);
    check("arst_valid", sample_valid_out, 0);
    check("arst_overrun", overrun_out, 0);
    step();
    step();
    rst_in = 1'b1;
    step();
    do_tick(1, 8, 'h10000, 8, nv, off, val, a1, a2, on);
    check("arst_first_addr", a1, 0);
    check("arst_first_addr_b", a2, 1);
    check("arst_first_latency", off, 5);

    // ---------------- random ticks vs. model ----------------
    apply_reset();
    mphase = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int blk = 0; blk < 6; blk++) begin
      if ($urandom_range(0, 7) == 0) w = 0;
      else                           w = int'($urandom_range(1, 40));
      for (int j = 0; j < 10; j++) begin
        nt  = ($urandom_range(0, 9) != 0);
        inc = int'($urandom_range(0, 'h30000));
        model_tick(nt, w, inc, ev, eo, ea1, ea2);
        do_tick(nt, w, inc, int'($urandom_range(6, 12)), nv, off, val, a1, a2, on);
        check($sformatf("rnd%0d_%0d_count", blk, j), nv, 1);
        check($sformatf("rnd%0d_%0d_value", blk, j), val, ev);
        check($sformatf("rnd%0d_%0d_latency", blk, j), off, eo);
        if (ea1 >= 0) begin
          check($sformatf("rnd%0d_%0d_addr_a", blk, j), a1, ea1);
          check($sformatf("rnd%0d_%0d_addr_b", blk, j), a2, ea2);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
